lr35902_oam_dma: RTL and testbench

//  OAM DMA controller (FF46). A CPU write of page byte P starts a copy of LEN bytes

---
 rtl/gb_defs.sv | 27 ++
 rtl/lr35902_oam_dma.sv | 103 ++++++++++
 tb/tb_lr35902_oam_dma.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/gb_defs.sv
// Shared LR35902 definitions: OAM DMA constants, states and page helpers.
package gb_defs;

    localparam int          DMA_LEN      = 160;
    localparam int          M_CYCLE      = 4;
    localparam logic [7:0]  REG_DMA      = 8'h46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [7:0]  PAGE_VRAM_LO = 8'h80;
    localparam logic [7:0]  PAGE_VRAM_HI = 8'h9F;
    localparam logic [7:0]  PAGE_ECHO    = 8'hE0;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_START,
        DMA_XFER
    } dma_state_e;

    // E0..FF alias the echo of work RAM at C0..DF
    function automatic logic [7:0] dma_src_page(input logic [7:0] p);
        return (p >= PAGE_ECHO) ? p - 8'h20 : p;
    endfunction

    function automatic logic is_vram_page(input logic [7:0] p);
        return (p >= PAGE_VRAM_LO) && (p <= PAGE_VRAM_HI);
    endfunction

endpackage

// File: rtl/lr35902_oam_dma.sv
// OAM DMA controller (FF46): copies LEN bytes from page P to OAM.
// Outputs are registered one clock behind the internal state/sub/idx counters.
module lr35902_oam_dma
    import gb_defs::*;
#(
    parameter int LEN  = DMA_LEN,
    parameter int TCYC = M_CYCLE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write,
    input  logic [7:0]  reg_din,
    output logic [7:0]  reg_dout,
    input  logic [7:0]  din,
    output logic [15:0] adr_rd,
    output logic        rd,
    output logic [7:0]  adr_wr,
    output logic [7:0]  dout,
    output logic        wr,
    output logic        active,
    output logic        drvext
);

    localparam logic [1:0] SUB_LAST = 2'(TCYC - 1);
    localparam logic [7:0] IDX_LAST = 8'(LEN - 1);

    dma_state_e state;
    logic [1:0] sub;
    logic [7:0] idx;
    logic [7:0] src_q;

    logic in_xfer;
    logic last_sub;

    assign in_xfer  = (state == DMA_XFER);
    assign last_sub = (sub == SUB_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= DMA_IDLE;
            sub      <= 2'd0;
            idx      <= 8'd0;
            src_q    <= 8'd0;
            reg_dout <= 8'd0;
            adr_rd   <= 16'd0;
            adr_wr   <= 8'd0;
            dout     <= 8'd0;
            rd       <= 1'b0;
            wr       <= 1'b0;
            active   <= 1'b0;
            drvext   <= 1'b0;
        end else begin
            active <= in_xfer;
            rd     <= in_xfer;
            drvext <= in_xfer && !is_vram_page(src_q);
            wr     <= in_xfer && last_sub;
            if (in_xfer) begin
                adr_rd <= {src_q, idx};
                adr_wr <= idx;
            end
            // din answers the address presented since this byte's first clock
            if (in_xfer && last_sub)
                dout <= din;

            if (reg_write) begin
                src_q    <= dma_src_page(reg_din);
                reg_dout <= reg_din;
                sub      <= 2'd0;
                idx      <= 8'd0;
                state    <= DMA_START;
            end else begin
                unique case (state)
                    DMA_IDLE: begin
                        sub <= 2'd0;
                        idx <= 8'd0;
                    end
                    DMA_START: begin
                        sub <= sub + 2'd1;
                        if (last_sub) begin
                            sub   <= 2'd0;
                            idx   <= 8'd0;
                            state <= DMA_XFER;
                        end
                    end
                    DMA_XFER: begin
                        sub <= sub + 2'd1;
                        if (last_sub) begin
                            sub <= 2'd0;
                            if (idx == IDX_LAST) begin
                                idx   <= 8'd0;
                                state <= DMA_IDLE;
                            end else begin
                                idx <= idx + 8'd1;
                            end
                        end
                    end
                    default: state <= DMA_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lr35902_oam_dma.sv
// Scoreboard bench for lr35902_oam_dma: expected OAM writes queued by
// the stimulus, popped and compared by a monitor on every wr pulse.
module tb_lr35902_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [7:0]  reg_din;
    logic [7:0]  reg_dout;
    logic [7:0]  din;
    logic [15:0] adr_rd;
    logic        rd;
    logic [7:0]  adr_wr;
    logic [7:0]  dout;
    logic        wr;
    logic        active;
    logic        drvext;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  i;
        logic [7:0]  d;
    } exp_t;

    exp_t q[$];
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   wr_total = 0;

    always #5 clk = ~clk;

    // Source memory model: each byte is its low address bits xor 5A
    always_comb din = adr_rd[7:0] ^ 8'h5A;

    lr35902_oam_dma dut (
        .clk       (clk),
        .reset     (reset),
        .reg_write (reg_write),
        .reg_din   (reg_din),
        .reg_dout  (reg_dout),
        .din       (din),
        .adr_rd    (adr_rd),
        .rd        (rd),
        .adr_wr    (adr_wr),
        .dout      (dout),
        .wr        (wr),
        .active    (active),
        .drvext    (drvext)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_run(input logic [7:0] src, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.a = {src, 8'(i)};
            e.i = 8'(i);
            e.d = 8'(i) ^ 8'h5A;
            q.push_back(e);
        end
    endtask

    task automatic write_reg(input logic [7:0] p);
        @(posedge clk);
        #1;
        reg_din   = p;
        reg_write = 1'b1;
        @(posedge clk);
        #1;
        reg_write = 1'b0;
    endtask

    task automatic wait_wr(input string nm, input logic [7:0] ix);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (wr && adr_wr == ix) begin
                ok = 1'b1;
                break;
            end
        end
        check(nm, int'(ok), 1);
    endtask

    task automatic measure(input string nm, input int exp_low,
                           input logic exp_drv);
        int lo;
        int hi;
        int bad;
        lo  = 0;
        hi  = 0;
        bad = 0;
        @(negedge clk);
        while (!active && lo < 50) begin
            lo++;
            @(negedge clk);
        end
        check({nm, " start delay"}, lo, exp_low);
        while (active && hi < 1000) begin
            if (drvext !== exp_drv || rd !== 1'b1)
                bad++;
            hi++;
            @(negedge clk);
        end
        check({nm, " active len"}, hi, 640);
        check({nm, " drvext/rd"}, bad, 0);
        check({nm, " queue drained"}, q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (wr) begin
            wr_total++;
            if (q.size() == 0) begin
                check("unexpected wr", 1, 0);
            end else begin
                e = q.pop_front();
                check("adr_wr", int'(adr_wr), int'(e.i));
                check("dout", int'(dout), int'(e.d));
                check("adr_rd", int'(adr_rd), int'(e.a));
            end
        end
    end

    initial begin
        int wr0;
        reset     = 1'b1;
        reg_write = 1'b0;
        reg_din   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst reg_dout", int'(reg_dout), 0);
        check("rst adr_rd", int'(adr_rd), 0);
        check("rst adr_wr", int'(adr_wr), 0);
        check("rst dout", int'(dout), 0);
        check("rst strobes", int'({rd, wr, active, drvext}), 0);

        // 1: work RAM page, external bus owned
        push_run(8'hC0, 160);
        write_reg(8'hC0);
        check("t1 reg_dout", int'(reg_dout), 8'hC0);
        measure("t1", 5, 1'b1);

        // 2: VRAM page keeps the external bus with the CPU
        push_run(8'h85, 160);
        write_reg(8'h85);
        measure("t2", 5, 1'b0);

        // 3: echo page F1 reads from D1
        push_run(8'hD1, 160);
        write_reg(8'hF1);
        check("t3 reg_dout", int'(reg_dout), 8'hF1);
        measure("t3", 5, 1'b1);

        // 4: restart on the wr clock of index 40
        wr0 = wr_total;
        push_run(8'hC0, 65);
        push_run(8'hD0, 160);
        write_reg(8'hC0);
        wait_wr("t4 reach 40", 8'h40);
        reg_din   = 8'hD0;
        reg_write = 1'b1;
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        @(negedge clk);
        check("t4 active hold", int'(active), 1);
        measure("t4", 4, 1'b1);
        check("t4 wr count", wr_total - wr0, 225);
        check("t4 reg_dout", int'(reg_dout), 8'hD0);

        // 5: reset mid-transfer, then a clean transfer
        push_run(8'h30, 33);
        write_reg(8'h30);
        wait_wr("t5 reach 20", 8'h20);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5 strobes", int'({rd, wr, active, drvext}), 0);
        check("t5 reg_dout", int'(reg_dout), 0);
        check("t5 queue", q.size(), 0);
        push_run(8'h10, 160);
        write_reg(8'h10);
        measure("t5", 5, 1'b1);

        // 6: write on the final wr clock
        wr0 = wr_total;
        push_run(8'h22, 160);
        push_run(8'h9A, 160);
        write_reg(8'h22);
        wait_wr("t6 reach 9F", 8'h9F);
        reg_din   = 8'h9A;
        reg_write = 1'b1;
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        measure("t6", 5, 1'b0);
        check("t6 wr count", wr_total - wr0, 320);

        repeat (10) @(negedge clk);
        check("final queue", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
